// File: rtl/ps2_mouse_tracker_pkg.sv
// Shared constants, state types and axis helpers for the PS/2 mouse tracker.
// Screen limits mirror the 800x600 display timing used by the VGA path.
package ps2_mouse_tracker_pkg;

  localparam int HOR_PIXELS = 800;
  localparam int VER_PIXELS = 600;
  localparam int X_MAX_DEF  = HOR_PIXELS - 1;
  localparam int Y_MAX_DEF  = VER_PIXELS - 1;

  // Byte0 bit positions of a stream-mode packet
  localparam int B0_LEFT  = 0;
  localparam int B0_RIGHT = 1;
  localparam int B0_ONE   = 3;
  localparam int B0_XSIGN = 4;
  localparam int B0_YSIGN = 5;
  localparam int B0_XOVF  = 6;
  localparam int B0_YOVF  = 7;

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {PKT_B0, PKT_B1, PKT_B2, PKT_UPD} pkt_state_t;

  // An overflowed axis is treated as no movement.
  function automatic logic signed [8:0] axis_delta(input logic sign, input logic ovf,
                                                   input logic [7:0] mag);
    return ovf ? 9'sd0 : $signed({sign, mag});
  endfunction

  function automatic logic [11:0] clamp_axis(input logic signed [13:0] v,
                                             input logic [11:0] lim);
    if (v < 14'sd0) return 12'd0;
    else if (v > $signed({2'b00, lim})) return lim;
    else return v[11:0];
  endfunction

endpackage

// File: rtl/ps2_mouse_tracker_if.sv
// Mouse interface: raw PS/2 pins in, cursor position/buttons/strobes out.
// pkt_valid and frame_err are one-cycle strobes with no ready; consumers sample them on that cycle, and position/buttons hold between pkt_valid pulses.
interface ps2_mouse_tracker_if;
  import ps2_mouse_tracker_pkg::*;

  logic        ps2_clk;
  logic        ps2_data;
  logic [11:0] mouse_xpos;
  logic [11:0] mouse_ypos;
  logic        mouse_left;
  logic        mouse_right;
  logic        pkt_valid;
  logic        frame_err;
  rx_state_t   rx_state;
  pkt_state_t  pkt_state;

  modport master (
    input  ps2_clk, ps2_data,
    output mouse_xpos, mouse_ypos, mouse_left, mouse_right, pkt_valid, frame_err,
           rx_state, pkt_state
  );

  modport slave (
    output ps2_clk, ps2_data,
    input  mouse_xpos, mouse_ypos, mouse_left, mouse_right, pkt_valid, frame_err,
           rx_state, pkt_state
  );
endinterface

// File: rtl/ps2_mouse_tracker_rx.sv
// PS/2 frame receiver: pin synchronisers, falling-edge detect, 11-bit frame FSM
// with odd-parity/stop check and an in-frame inactivity watchdog.
module ps2_rx
  import ps2_mouse_tracker_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 40000
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      ps2_clk,
  input  logic      ps2_data,
  output logic [7:0] rx_byte,
  output logic      byte_valid,
  output logic      rx_err,
  output rx_state_t state
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  // Fires one cycle early: the top spends one more cycle registering frame_err.
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 2);

  logic clk_s1, clk_s2, clk_s3;
  logic dat_s1, dat_s2;
  logic fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_s3 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      clk_s3 <= clk_s2;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  assign fall = clk_s3 & ~clk_s2;

  logic [7:0]      shreg;
  logic [2:0]      bit_cnt;
  logic            par_bit;
  logic [WD_W-1:0] wd_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RX_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      par_bit    <= 1'b0;
      wd_cnt     <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      rx_err     <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      rx_err     <= 1'b0;
      if (state == RX_IDLE || fall) wd_cnt <= '0;
      else                          wd_cnt <= wd_cnt + WD_W'(1);

      if (state != RX_IDLE && !fall && wd_cnt == WD_LIMIT) begin
        state  <= RX_IDLE;
        rx_err <= 1'b1;
      end else if (fall) begin
        case (state)
          RX_IDLE: begin
            if (!dat_s2) begin
              state   <= RX_DATA;
              bit_cnt <= '0;
            end
          end
          RX_DATA: begin
            shreg   <= {dat_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= RX_PARITY;
          end
          RX_PARITY: begin
            par_bit <= dat_s2;
            state   <= RX_STOP;
          end
          RX_STOP: begin
            // Odd parity across data+parity and a high stop bit
            if (dat_s2 && (^{shreg, par_bit})) begin
              rx_byte    <= shreg;
              byte_valid <= 1'b1;
            end else begin
              rx_err <= 1'b1;
            end
            state <= RX_IDLE;
          end
          default: state <= RX_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse tracker top: assembles 3-byte stream packets from ps2_rx and
// integrates the signed deltas into clamped screen coordinates and button levels.
module ps2_mouse_tracker
  import ps2_mouse_tracker_pkg::*;
#(
  parameter int X_MAX          = X_MAX_DEF,
  parameter int Y_MAX          = Y_MAX_DEF,
  parameter int TIMEOUT_CYCLES = 40000,
  parameter int INIT_X         = 400,
  parameter int INIT_Y         = 300
) (
  input logic                 clk,
  input logic                 rst_n,
  ps2_mouse_tracker_if.master m
);

  localparam logic [11:0] X_LIM = 12'(X_MAX);
  localparam logic [11:0] Y_LIM = 12'(Y_MAX);

  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       rx_err;

  ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk    (m.ps2_clk),
    .ps2_data   (m.ps2_data),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .rx_err     (rx_err),
    .state      (m.rx_state)
  );

  pkt_state_t pkt_state;
  logic       b0_left, b0_right, b0_xs, b0_ys, b0_xo, b0_yo;
  logic [7:0] b1, b2;
  logic [11:0] xpos, ypos;
  logic       left_q, right_q, pkt_valid_q, frame_err_q;

  logic signed [8:0]  dx, dy;
  logic signed [13:0] x_sum, y_sum;

  // PS/2 Y is up-positive while the screen is down-positive, hence the subtraction.
  always_comb begin
    dx    = axis_delta(b0_xs, b0_xo, b1);
    dy    = axis_delta(b0_ys, b0_yo, b2);
    x_sum = $signed({2'b00, xpos}) + $signed({{5{dx[8]}}, dx});
    y_sum = $signed({2'b00, ypos}) - $signed({{5{dy[8]}}, dy});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_state   <= PKT_B0;
      b0_left     <= 1'b0;
      b0_right    <= 1'b0;
      b0_xs       <= 1'b0;
      b0_ys       <= 1'b0;
      b0_xo       <= 1'b0;
      b0_yo       <= 1'b0;
      b1          <= '0;
      b2          <= '0;
      xpos        <= 12'(INIT_X);
      ypos        <= 12'(INIT_Y);
      left_q      <= 1'b0;
      right_q     <= 1'b0;
      pkt_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      pkt_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      if (rx_err) begin
        pkt_state   <= PKT_B0;
        frame_err_q <= 1'b1;
      end else begin
        case (pkt_state)
          PKT_B0: begin
            if (byte_valid) begin
              // A byte0 without its always-one bit means we are misaligned; stay and resync.
              if (rx_byte[B0_ONE]) begin
                b0_left   <= rx_byte[B0_LEFT];
                b0_right  <= rx_byte[B0_RIGHT];
                b0_xs     <= rx_byte[B0_XSIGN];
                b0_ys     <= rx_byte[B0_YSIGN];
                b0_xo     <= rx_byte[B0_XOVF];
                b0_yo     <= rx_byte[B0_YOVF];
                pkt_state <= PKT_B1;
              end else begin
                frame_err_q <= 1'b1;
              end
            end
          end
          PKT_B1: begin
            if (byte_valid) begin
              b1        <= rx_byte;
              pkt_state <= PKT_B2;
            end
          end
          PKT_B2: begin
            if (byte_valid) begin
              b2        <= rx_byte;
              pkt_state <= PKT_UPD;
            end
          end
          PKT_UPD: begin
            xpos        <= clamp_axis(x_sum, X_LIM);
            ypos        <= clamp_axis(y_sum, Y_LIM);
            left_q      <= b0_left;
            right_q     <= b0_right;
            pkt_valid_q <= 1'b1;
            pkt_state   <= PKT_B0;
          end
          default: pkt_state <= PKT_B0;
        endcase
      end
    end
  end

  assign m.mouse_xpos  = xpos;
  assign m.mouse_ypos  = ypos;
  assign m.mouse_left  = left_q;
  assign m.mouse_right = right_q;
  assign m.pkt_valid   = pkt_valid_q;
  assign m.frame_err   = frame_err_q;
  assign m.pkt_state   = pkt_state;

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Bench for ps2_mouse_tracker: drives PS/2 frames, predicts cursor state with an
// integer model and checks every pkt_valid against an expected queue.
module tb_ps2_mouse_tracker;

  localparam int T_OUT   = 300;  // shortened watchdog keeps the run short
  localparam int HALF    = 15;   // PS/2 half-bit in clk cycles
  localparam int SYNC_LAT = 3;   // pin change -> edge acted on
  localparam int PKT_LAT  = SYNC_LAT + 2;

  logic clk;
  logic rst_n;
  int   cyc;

  ps2_mouse_tracker_if mif();

  ps2_mouse_tracker #(
    .X_MAX(799), .Y_MAX(599), .TIMEOUT_CYCLES(T_OUT), .INIT_X(400), .INIT_Y(300)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .m     (mif.master)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [25:0] exp_q[$];
  logic [25:0] e_item;
  int n_checks, n_err;
  int pkt_cnt, err_cnt, err_cyc;
  int exp_pkts, exp_errs;
  int last_stop_cyc, last_fall_cyc;
  int mx, my;
  bit ml, mr;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (mif.pkt_valid) begin
        pkt_cnt++;
        check_val("pulse_excl", 32'(mif.frame_err), 0);
        check_val("pkt_lat", cyc - last_stop_cyc, PKT_LAT);
        if (exp_q.size() == 0) check_val("pkt_expected_q", 0, 1);
        else begin
          e_item = exp_q.pop_front();
          check_val("pkt_out", {6'b0, mif.mouse_xpos, mif.mouse_ypos, mif.mouse_left,
                                mif.mouse_right}, {6'b0, e_item});
        end
      end
      if (mif.frame_err) begin
        err_cnt++;
        err_cyc = cyc;
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic int clamp_i(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  task automatic model_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    int dx, dy;
    dx = b0[6] ? 0 : (b0[4] ? int'(b1) - 256 : int'(b1));
    dy = b0[7] ? 0 : (b0[5] ? int'(b2) - 256 : int'(b2));
    mx = clamp_i(mx + dx, 799);
    my = clamp_i(my - dy, 599);
    ml = b0[0];
    mr = b0[1];
    exp_q.push_back({12'(mx), 12'(my), ml, mr});
    exp_pkts++;
  endtask

  // ---------------- drivers ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] f;
    logic par;
    par = ~(^b) ^ bad_par;
    f = {1'b1, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      mif.ps2_data = f[i];
      wait_cycles(HALF);
      mif.ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      if (i == 10) last_stop_cyc = cyc;
      wait_cycles(HALF);
      mif.ps2_clk = 1'b1;
    end
    mif.ps2_data = 1'b1;
    wait_cycles(2 * HALF);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    send_bits(b, bad_par, 11);
  endtask

  task automatic send_good(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    model_pkt(b0, b1, b2);
    send_frame(b0, 1'b0);
    send_frame(b1, 1'b0);
    send_frame(b2, 1'b0);
    wait_cycles(10);
    check_val("pkt_cnt", pkt_cnt, exp_pkts);
  endtask

  task automatic check_pos(input string tag, input int x, input int y);
    check_val({tag, "_x"}, 32'(mif.mouse_xpos), x);
    check_val({tag, "_y"}, 32'(mif.mouse_ypos), y);
  endtask

  task automatic wait_err(input int target, input int bound);
    int k;
    k = 0;
    while (err_cnt < target && k < bound) begin
      wait_cycles(1);
      k++;
    end
    check_val("err_cnt", err_cnt, target);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mif.ps2_clk = 1'b1;
    mif.ps2_data = 1'b1;
    wait_cycles(5);
    rst_n = 1'b1;
    mx = 400; my = 300; ml = 0; mr = 0;
    wait_cycles(2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] rb0, rb1, rb2;
    n_checks = 0; n_err = 0; pkt_cnt = 0; err_cnt = 0; err_cyc = 0;
    exp_pkts = 0; exp_errs = 0; last_stop_cyc = 0; last_fall_cyc = 0;
    rst_n = 1'b0;
    mif.ps2_clk = 1'b1;
    mif.ps2_data = 1'b1;
    wait_cycles(3);
    do_reset();

    // Reset values and quiet line
    check_pos("rst", 400, 300);
    check_val("rst_left", 32'(mif.mouse_left), 0);
    check_val("rst_right", 32'(mif.mouse_right), 0);
    wait_cycles(2000);
    check_val("idle_pkts", pkt_cnt, 0);
    check_val("idle_errs", err_cnt, 0);

    // Basic moves
    send_good(8'h09, 8'h0A, 8'h00);
    check_pos("p1", 410, 300);
    check_val("p1_left", 32'(mif.mouse_left), 1);
    send_good(8'h28, 8'h00, 8'hFB);
    check_pos("p2", 410, 305);

    // Walk down to x=10, then clamp at 0
    for (int i = 0; i < 3; i++) send_good(8'h18, 8'h80, 8'h00);
    send_good(8'h18, 8'hF0, 8'h00);
    check_val("x_at10", 32'(mif.mouse_xpos), 10);
    send_good(8'h18, 8'hEC, 8'h00);
    check_val("clamp_lo", 32'(mif.mouse_xpos), 0);

    // Walk up to x=790, then clamp at 799
    for (int i = 0; i < 6; i++) send_good(8'h08, 8'h7F, 8'h00);
    send_good(8'h08, 8'h1C, 8'h00);
    check_val("x_at790", 32'(mif.mouse_xpos), 790);
    send_good(8'h08, 8'h14, 8'h00);
    check_val("clamp_hi", 32'(mif.mouse_xpos), 799);

    // Bad parity on byte1
    exp_errs++;
    send_frame(8'h08, 1'b0);
    send_frame(8'h10, 1'b1);
    wait_err(exp_errs, 50);
    check_val("badpar_pkts", pkt_cnt, exp_pkts);
    check_pos("badpar", mx, my);
    send_good(8'h1A, 8'h05, 8'h03);

    // Byte0 without bit3, then a valid packet
    exp_errs++;
    send_frame(8'h01, 1'b0);
    wait_err(exp_errs, 50);
    send_good(8'h09, 8'h02, 8'h04);
    check_val("resync_left", 32'(mif.mouse_left), 1);

    // Overflow: x ignored, y moves up by 5 screen rows
    send_good(8'h48, 8'hFF, 8'h05);
    check_pos("ovf", mx, my);

    // Randomized packets
    for (int i = 0; i < 10; i++) begin
      rb0 = 8'($urandom_range(0, 255)) | 8'h08;
      if ($urandom_range(0, 3) != 0) rb0 = rb0 & 8'h3F;
      rb1 = 8'($urandom_range(0, 255));
      rb2 = 8'($urandom_range(0, 255));
      send_good(rb0, rb1, rb2);
    end

    // Ragged frame: line stops after 5 falling edges
    exp_errs++;
    send_bits(8'h08, 1'b0, 5);
    wait_err(exp_errs, T_OUT + 100);
    check_val("timeout_lat", err_cyc - last_fall_cyc, T_OUT + SYNC_LAT);
    check_pos("timeout", mx, my);
    send_good(8'h0A, 8'h03, 8'hFE);

    // Reset in the middle of byte1
    send_frame(8'h08, 1'b0);
    send_bits(8'h55, 1'b0, 6);
    do_reset();
    check_pos("midrst", 400, 300);
    send_good(8'h09, 8'h10, 8'h20);
    check_pos("after_rst", 416, 268);

    wait_cycles(20);
    check_val("exp_q_empty", exp_q.size(), 0);
    check_val("total_pkts", pkt_cnt, exp_pkts);
    check_val("total_errs", err_cnt, exp_errs);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
